// File: rtl/census_param.sv
// census_param -- streaming census transform over a WIN_H x WIN_W window.
//
// Pixels arrive in raster order with their coordinates whenever en is high.
// WIN_H-1 line buffers keep the previous rows; each accepted pixel forms a
// WIN_H-tall column that is shifted into the window register. When the window
// is complete, the census code of its centre is produced two cycles after the
// triggering en.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         inData/row_in/col_in valid this cycle
//   inData     grey pixel (PIX_W)
//   row_in     row of inData (COORD_W)
//   col_in     column of inData (COORD_W)
//   outData    census code of the window centre (CT_W)
//   row_out    centre row of outData
//   col_out    centre column of outData
//   valid      one-cycle pulse, outData/row_out/col_out valid
//   frame_done one-cycle pulse after the last output of a frame
module census_param #(
  parameter int PIX_W   = 8,
  parameter int WIN_H   = 5,
  parameter int WIN_W   = 7,
  parameter int IMG_COL = 400,
  parameter int IMG_ROW = 200,
  parameter int COORD_W = 10,
  localparam int CT_W   = WIN_H*WIN_W-1,
  localparam int R      = (WIN_H-1)/2,
  localparam int C      = (WIN_W-1)/2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PIX_W-1:0]   inData,
  input  logic [COORD_W-1:0] row_in,
  input  logic [COORD_W-1:0] col_in,
  output logic [CT_W-1:0]    outData,
  output logic [COORD_W-1:0] row_out,
  output logic [COORD_W-1:0] col_out,
  output logic               valid,
  output logic               frame_done
);

  localparam int ADDR_W = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam int CEN    = R*WIN_W + C;   // raster position of the centre

  // ---------------------------------------------------------------- control
  logic              in_range;
  logic              accept;
  logic              start;
  logic              armed_reg;
  logic              fire;
  logic              last;
  logic [ADDR_W-1:0] addr;

  assign in_range = (row_in < COORD_W'(IMG_ROW)) && (col_in < COORD_W'(IMG_COL));
  assign accept   = en && in_range;
  assign start    = accept && (row_in == '0) && (col_in == '0);
  // Outputs are only trusted once a frame start has been seen since reset,
  // otherwise the line buffers may hold rows of an unknown frame.
  assign fire     = accept && (armed_reg || start) &&
                    (row_in >= COORD_W'(2*R)) && (col_in >= COORD_W'(2*C));
  assign last     = (row_in == COORD_W'(IMG_ROW-1)) && (col_in == COORD_W'(IMG_COL-1));
  assign addr     = col_in[ADDR_W-1:0];

  // ----------------------------------------------------------- line buffers
  // lb[k] holds row (row_in-1-k) at each column; reads are asynchronous so the
  // full column is available in the cycle the pixel arrives.
  logic [PIX_W-1:0] lb  [WIN_H-1][IMG_COL];
  logic [PIX_W-1:0] tap [WIN_H];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][addr] <= inData;
      for (int k = 1; k < WIN_H-1; k++) begin
        lb[k][addr] <= lb[k-1][addr];
      end
    end
  end

  // tap[0] is the newest row, tap[WIN_H-1] the oldest.
  always_comb begin
    tap[0] = inData;
    for (int k = 0; k < WIN_H-1; k++) begin
      tap[k+1] = lb[k][addr];
    end
  end

  // ------------------------------------------------- window and stage one
  // win[0][*] is the top (oldest) row, win[*][0] the leftmost (oldest) column.
  logic [PIX_W-1:0]   win [WIN_H][WIN_W];
  logic               fire_reg;
  logic               last_reg;
  logic [COORD_W-1:0] row_c_reg;
  logic [COORD_W-1:0] col_c_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN_H; i++) begin
        for (int j = 0; j < WIN_W; j++) begin
          win[i][j] <= '0;
        end
      end
      armed_reg <= 1'b0;
      fire_reg  <= 1'b0;
      last_reg  <= 1'b0;
      row_c_reg <= '0;
      col_c_reg <= '0;
    end else begin
      fire_reg <= fire;
      if (accept) begin
        for (int i = 0; i < WIN_H; i++) begin
          for (int j = 0; j < WIN_W-1; j++) begin
            win[i][j] <= win[i][j+1];
          end
          win[i][WIN_W-1] <= tap[WIN_H-1-i];
        end
        if (start) armed_reg <= 1'b1;
      end
      if (fire) begin
        row_c_reg <= row_in - COORD_W'(R);
        col_c_reg <= col_in - COORD_W'(C);
        last_reg  <= last;
      end
    end
  end

  // ------------------------------------------------------------ census code
  // Raster order over the window with the centre skipped; top-left lands in
  // the MSB, bottom-right in bit 0.
  logic [CT_W-1:0] code;

  for (genvar gi = 0; gi < WIN_H; gi++) begin : g_row
    for (genvar gj = 0; gj < WIN_W; gj++) begin : g_col
      localparam int POS = gi*WIN_W + gj;
      if (POS != CEN) begin : g_bit
        localparam int IDX = (POS < CEN) ? POS : POS-1;
        assign code[CT_W-1-IDX] = (win[gi][gj] < win[R][C]);
      end
    end
  end

  // ------------------------------------------------------------ stage two
  logic is_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= 1'b0;
      frame_done <= 1'b0;
      outData    <= '0;
      row_out    <= '0;
      col_out    <= '0;
      is_last    <= 1'b0;
    end else begin
      valid      <= fire_reg;
      frame_done <= valid && is_last;
      if (fire_reg) begin
        outData <= code;
        row_out <= row_c_reg;
        col_out <= col_c_reg;
        is_last <= last_reg;
      end
    end
  end

endmodule

// File: tb/tb_census_param.sv
// Self-checking bench for census_param (3x3 window, 8x4 image).
// A reference model keeps the frame in a plain 2-D array and computes every
// expected census code directly from the neighbourhood of its centre.
module tb_census_param;

  localparam int PIX_W = 8, WIN_H = 3, WIN_W = 3, IMG_COL = 8, IMG_ROW = 4, COORD_W = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic [PIX_W-1:0]   inData = '0;
  logic [COORD_W-1:0] row_in = '0;
  logic [COORD_W-1:0] col_in = '0;
  logic [7:0]         outData;
  logic [COORD_W-1:0] row_out;
  logic [COORD_W-1:0] col_out;
  logic               valid;
  logic               frame_done;

  census_param #(
    .PIX_W(PIX_W), .WIN_H(WIN_H), .WIN_W(WIN_W),
    .IMG_COL(IMG_COL), .IMG_ROW(IMG_ROW), .COORD_W(COORD_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .inData(inData),
    .row_in(row_in), .col_in(col_in), .outData(outData),
    .row_out(row_out), .col_out(col_out), .valid(valid),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, obs, exp_v, cyc);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    int         due;
    logic [7:0] code;
    int         row;
    int         col;
  } exp_t;

  exp_t       eq[$];
  int         fq[$];
  logic [7:0] img [IMG_ROW][IMG_COL];
  bit         armed = 0;
  logic [7:0] last_code = 0;
  int         last_row = 0, last_col = 0;
  int         nvalid = 0;
  int         npushed = 0;

  function automatic logic [7:0] census(input int r, input int c);
    logic [7:0] cd = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0))
          cd = {cd[6:0], (img[r+dr][c+dc] < img[r][c])};
    return cd;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0;
    end
  endtask

  task automatic send(input int r, input int c, input logic [7:0] d, input int gap);
    exp_t e;
    idle(gap);
    @(negedge clk);
    en = 1'b1; row_in = COORD_W'(r); col_in = COORD_W'(c); inData = d;
    if (r < IMG_ROW && c < IMG_COL) begin
      if (r == 0 && c == 0) armed = 1;
      img[r][c] = d;
      if (armed && r >= 2 && c >= 2) begin
        e.due = cyc + 2; e.code = census(r-1, c-1); e.row = r-1; e.col = c-1;
        eq.push_back(e);
        npushed++;
        if (r-1 == IMG_ROW-2 && c-1 == IMG_COL-2) fq.push_back(cyc + 3);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; rst = 1'b1;
    eq.delete(); fq.delete();
    armed = 0; last_code = 0; last_row = 0; last_col = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // -------------------------------------------------------------- monitor
  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("rst_valid", 32'(valid), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_outData", 32'(outData), 0);
      chk("rst_row_out", 32'(row_out), 0);
      chk("rst_col_out", 32'(col_out), 0);
    end else begin
      bit   ev;
      bit   efd;
      exp_t e;
      ev = (eq.size() > 0) && (eq[0].due == cyc);
      chk("valid", 32'(valid), 32'(ev));
      if (ev) begin
        e = eq.pop_front();
        chk("outData", 32'(outData), 32'(e.code));
        chk("row_out", 32'(row_out), 32'(e.row));
        chk("col_out", 32'(col_out), 32'(e.col));
        last_code = e.code; last_row = e.row; last_col = e.col;
        nvalid++;
        $display("out (%0d,%0d) code %02h at cycle %0d", e.row, e.col, e.code, cyc);
      end else if (!valid) begin
        chk("hold_outData", 32'(outData), 32'(last_code));
        chk("hold_row_out", 32'(row_out), 32'(last_row));
        chk("hold_col_out", 32'(col_out), 32'(last_col));
      end
      efd = (fq.size() > 0) && (fq[0] == cyc);
      chk("frame_done", 32'(frame_done), 32'(efd));
      if (efd) void'(fq.pop_front());
    end
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Constant image, full rate: twelve zero codes.
    nvalid = 0;
    for (int r = 0; r < IMG_ROW; r++)
      for (int c = 0; c < IMG_COL; c++) send(r, c, 8'h80, 0);
    idle(5);
    chk("n_valid_const", 32'(nvalid), 12);

    // Ramp (value = column), full rate.
    nvalid = 0;
    for (int r = 0; r < IMG_ROW; r++)
      for (int c = 0; c < IMG_COL; c++) send(r, c, 8'(c), 0);
    idle(5);
    chk("n_valid_ramp", 32'(nvalid), 12);

    // Same ramp with en every 13 cycles.
    nvalid = 0;
    for (int r = 0; r < IMG_ROW; r++)
      for (int c = 0; c < IMG_COL; c++) send(r, c, 8'(c), 12);
    idle(5);
    chk("n_valid_sparse", 32'(nvalid), 12);

    // Reset in the middle of a frame, continue without a frame start, restart.
    for (int r = 0; r < IMG_ROW; r++)
      for (int c = 0; c < IMG_COL; c++)
        if (r < 2 || (r == 2 && c <= 4)) send(r, c, 8'(c), 0);
    do_reset();
    nvalid = 0;
    for (int c = 5; c < IMG_COL; c++) send(2, c, 8'(c), 0);
    for (int c = 0; c < IMG_COL; c++) send(3, c, 8'(c), 0);
    idle(4);
    chk("n_valid_unarmed", 32'(nvalid), 0);
    for (int r = 0; r < IMG_ROW; r++)
      for (int c = 0; c < IMG_COL; c++) send(r, c, 8'($urandom_range(0, 255)), 0);
    idle(5);
    chk("n_valid_after_rst", 32'(nvalid), 12);

    // Mid-frame restart without reset, plus out-of-range pixels.
    nvalid = 0;
    npushed = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < IMG_COL; c++)
        if (r < 2 || c <= 3) send(r, c, 8'($urandom_range(0, 255)), $urandom_range(0, 3));
    for (int r = 0; r < IMG_ROW; r++)
      for (int c = 0; c < IMG_COL; c++) begin
        send(r, c, 8'($urandom_range(0, 255)), $urandom_range(0, 3));
        if (r == 2 && c == 1) send(2, 8, 8'hFF, 0);
        if (r == 1 && c == 5) send(4, 0, 8'h00, 1);
      end
    idle(5);
    chk("n_valid_restart", 32'(nvalid), 32'(npushed));
    chk("n_valid_restart_count", 32'(nvalid), 14);

    // Random frames with random gaps and narrow value range (many ties).
    for (int f = 0; f < 3; f++) begin
      nvalid = 0;
      for (int r = 0; r < IMG_ROW; r++)
        for (int c = 0; c < IMG_COL; c++)
          send(r, c, 8'($urandom_range(0, 3)), $urandom_range(0, 2));
      idle(5);
      chk("n_valid_random", 32'(nvalid), 12);
    end

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/census_param.md
CENSUS_PARAM -- requirements
Module: census_param

Interface
REQ-001 SHALL have parameter PIX_W, default 8, grey pixel width.
REQ-002 SHALL have parameter WIN_H, default 5, window height (odd, 3..7).
REQ-003 SHALL have parameter WIN_W, default 7, window width (odd, 3..9).
REQ-004 SHALL have parameter IMG_COL, default 400, pixels per row.
REQ-005 SHALL have parameter IMG_ROW, default 200, rows per frame.
REQ-006 SHALL have parameter COORD_W, default 10, row/col coordinate width.
REQ-007 SHALL define CT_W = WIN_H*WIN_W-1, R = (WIN_H-1)/2, C = (WIN_W-1)/2.
REQ-008 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-009 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-010 SHALL have port en  input  1  inData/row_in/col_in valid this cycle.
REQ-011 SHALL have port inData  input  PIX_W  grey pixel, raster order.
REQ-012 SHALL have port row_in  input  COORD_W  row of inData.
REQ-013 SHALL have port col_in  input  COORD_W  column of inData.
REQ-014 SHALL have port outData  output  CT_W  census code of window centre.
REQ-015 SHALL have port row_out  output  COORD_W  centre row of outData.
REQ-016 SHALL have port col_out  output  COORD_W  centre column of outData.
REQ-017 SHALL have port valid  output  1  one-cycle pulse, outData/row_out/col_out valid.
REQ-018 SHALL have port frame_done  output  1  one-cycle pulse after last output of a frame.

Function
REQ-019 SHALL accept one pixel per en cycle; en may be high on consecutive cycles (full rate) or sparse (any gap); no backpressure.
REQ-020 SHALL hold WIN_H-1 line buffers of IMG_COL x PIX_W, written at col_in on each en, forming a WIN_H-tall column shifted into a WIN_H x WIN_W window register on each en.
REQ-021 SHALL compute, when en arrives with row_in >= 2R and col_in >= 2C, the code for centre (row_in-R, col_in-C); otherwise no output.
REQ-022 SHALL set each code bit to 1 iff neighbour < centre (unsigned, strict); equal gives 0.
REQ-023 SHALL order bits raster over the window skipping centre, top-left neighbour in bit CT_W-1, bottom-right in bit 0.
REQ-024 SHALL assert valid exactly 2 clk cycles after the triggering en cycle (fixed latency, independent of en spacing), with row_out/col_out equal to the centre coordinates.
REQ-025 SHALL hold outData/row_out/col_out stable between valid pulses (last value retained).
REQ-026 SHALL pulse frame_done one cycle after the valid for centre (IMG_ROW-1-R, IMG_COL-1-C).
REQ-027 SHALL treat en with row_in=0, col_in=0 as frame start: results in flight complete normally; no output for the new frame until REQ-021 holds again.
REQ-028 SHALL ignore en with row_in >= IMG_ROW or col_in >= IMG_COL (no buffer write, no window shift, no output).
REQ-029 SHALL not emit border centres (rows < R or > IMG_ROW-1-R, cols < C or > IMG_COL-1-C); interior output count per frame SHALL be (IMG_ROW-2R)*(IMG_COL-2C).

Reset
REQ-030 SHALL, while rst high, force valid=0, frame_done=0, outData=0, row_out=0, col_out=0 and clear the pipeline; line buffer contents need not clear.
REQ-031 SHALL, on rst deassertion mid-frame, produce no valid until a frame start (REQ-027) followed by REQ-021 conditions.

Verification (config WIN_H=3, WIN_W=3, IMG_COL=8, IMG_ROW=4, PIX_W=8)
REQ-032 SHALL cover: constant image 0x80, en every cycle -> 12 valid pulses, all outData=0x00, first at (1,1) 2 cycles after en of pixel (2,2).
REQ-033 SHALL cover: pixel value = col_in -> every outData=0x94 (left column neighbours less than centre).
REQ-034 SHALL cover: same ramp image with en every 13 cycles -> output sequence identical to REQ-033, each valid 2 cycles after its trigger en.
REQ-035 SHALL cover: frame end -> frame_done pulses one cycle after valid with row_out=2, col_out=6; none otherwise.
REQ-036 SHALL cover: rst asserted at pixel (2,4), released, frame restarted at (0,0) -> outputs 0 during rst, no stale valid, then 12 correct outputs.
REQ-037 SHALL cover: new frame started at (0,0) mid-frame without rst, plus en at col_in=8 -> no output until pixel (2,2) of new frame; col_in=8 pixel ignored.
